// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: turn/hazard request inputs plus lamp and status outputs of turn_sequencer
interface turn_sequencer_if #(
    parameter int LEDS = 3,
    parameter int SW = $clog2(LEDS + 1)
);
    logic            left_req;
    logic            right_req;
    logic            hazard_req;
    logic [LEDS-1:0] left_leds;
    logic [LEDS-1:0] right_leds;
    logic [1:0]      mode;
    logic [SW-1:0]   step;
    modport master (
        output left_req, right_req, hazard_req,
        input  left_leds, right_leds, mode, step
    );
    modport slave (
        input  left_req, right_req, hazard_req,
        output left_leds, right_leds, mode, step
    );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: turn-signal / hazard lamp sequencer stepped by a TICK_DIV prescaler
module turn_sequencer #(
    parameter int LEDS = 3,
    parameter int TICK_DIV = 4,
    parameter int SW = $clog2(LEDS + 1)
) (
    input logic             clock,
    input logic             reset_n,
    turn_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, HAZARD = 2'd3;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      mode_q, mode_d, req;
    logic [SW-1:0]   step_q, step_d;
    logic [LEDS-1:0] therm, flash;
    logic            tick;
    always_comb begin
        tick = pre_q == PW'(TICK_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
        req = (bus.hazard_req || (bus.left_req && bus.right_req)) ? HAZARD :
              bus.left_req ? LEFT : bus.right_req ? RIGHT : IDLE;
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            case (mode_q)
                IDLE: begin
                    mode_d = req;
                    step_d = '0;
                end
                HAZARD: begin
                    mode_d = step_q == '0 ? HAZARD : req;
                    step_d = step_q == '0 ? SW'(1) : '0;
                end
                // LEFT/RIGHT: hazard preempts at once, otherwise the request is only re-read at the end
                default: begin
                    if (req == HAZARD || step_q == SW'(LEDS)) begin
                        mode_d = req;
                        step_d = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            mode_q <= IDLE;
            step_q <= '0;
        end else begin
            pre_q <= pre_d;
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end
    always_comb begin
        therm = ~({LEDS{1'b1}} << step_q);
        flash = {LEDS{mode_q == HAZARD && step_q == SW'(1)}};
    end
    assign bus.left_leds = mode_q == LEFT ? therm : flash;
    assign bus.right_leds = mode_q == RIGHT ? therm : flash;
    assign bus.mode = mode_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed and randomized checks of turn_sequencer against a behavioural model
module tb_turn_sequencer;
    localparam int LEDS = 3;
    localparam int TD = 4;
    localparam int SW = $clog2(LEDS + 1);
    logic clock = 1'b0;
    logic reset_n;
    int vectors = 0;
    int miscompares = 0;
    int m_pre = 0;
    int m_mode = 0;
    int m_step = 0;

    turn_sequencer_if #(.LEDS(LEDS)) bus();

    turn_sequencer #(.LEDS(LEDS), .TICK_DIV(TD)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int mode, input int step, input int l, input int r);
        vectors++;
        if (bus.mode !== 2'(mode) || bus.step !== SW'(step) ||
            bus.left_leds !== LEDS'(l) || bus.right_leds !== LEDS'(r)) begin
            miscompares++;
            $display("FAIL %s @%0t: got mode=%0d step=%0d left=%b right=%b, want mode=%0d step=%0d left=%b right=%b",
                     name, $time, bus.mode, bus.step, bus.left_leds, bus.right_leds,
                     mode, step, LEDS'(l), LEDS'(r));
        end
    endtask

    function automatic int eff(input logic l, input logic r, input logic h);
        return (h || (l && r)) ? 3 : l ? 1 : r ? 2 : 0;
    endfunction

    // side: 1 = left, 2 = right
    function automatic int lamps(input int side, input int mode, input int step);
        if (mode == side) return (1 << step) - 1;
        return (mode == 3 && step == 1) ? (1 << LEDS) - 1 : 0;
    endfunction

    always @(negedge reset_n) begin
        m_pre = 0;
        m_mode = 0;
        m_step = 0;
    end

    always @(posedge clock) begin
        int rq;
        if (reset_n === 1'b1) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                rq = eff(bus.left_req, bus.right_req, bus.hazard_req);
                if (m_mode == 0) begin
                    m_mode = rq;
                    m_step = 0;
                end else if (m_mode == 3) begin
                    if (m_step == 0) m_step = 1;
                    else begin
                        m_step = 0;
                        m_mode = rq;
                    end
                end else if (rq == 3) begin
                    m_mode = 3;
                    m_step = 0;
                end else if (m_step == LEDS) begin
                    m_step = 0;
                    m_mode = rq;
                end else begin
                    m_step++;
                end
            end else begin
                m_pre++;
            end
        end
        #1;
        check("model", m_mode, m_step, lamps(1, m_mode, m_step), lamps(2, m_mode, m_step));
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.left_req = 1'b0;
        bus.right_req = 1'b0;
        bus.hazard_req = 1'b0;
        repeat (2) @(negedge clock);
        check("reset", 0, 0, 0, 0);
        bus.left_req = 1'b1;
        reset_n = 1'b1;
        wait_edges(3); check("no_tick_edge3", 0, 0, 0, 0);
        wait_edges(1); check("first_tick_edge4", 1, 0, 0, 0);
        wait_edges(4); check("left_001", 1, 1, 1, 0);
        wait_edges(4); check("left_011", 1, 2, 3, 0);
        wait_edges(4); check("left_111", 1, 3, 7, 0);
        wait_edges(3); check("left_111_hold", 1, 3, 7, 0);
        wait_edges(1); check("left_wrap", 1, 0, 0, 0);
        wait_edges(8); check("left_step2", 1, 2, 3, 0);
        @(negedge clock) bus.hazard_req = 1'b1;
        wait_edges(4); check("hazard_preempt", 3, 0, 0, 0);
        @(negedge clock) bus.hazard_req = 1'b0;
        wait_edges(4); check("hazard_on", 3, 1, 7, 7);
        wait_edges(4); check("hazard_back_left", 1, 0, 0, 0);
        wait_edges(4); check("left_step1", 1, 1, 1, 0);
        @(negedge clock) bus.left_req = 1'b0;
        wait_edges(4); check("drop_011", 1, 2, 3, 0);
        wait_edges(4); check("drop_111", 1, 3, 7, 0);
        wait_edges(4); check("drop_idle", 0, 0, 0, 0);
        @(negedge clock) begin
            bus.left_req = 1'b1;
            bus.right_req = 1'b1;
        end
        wait_edges(4); check("both_hazard", 3, 0, 0, 0);
        wait_edges(4); check("both_on", 3, 1, 7, 7);
        wait_edges(4); check("both_off", 3, 0, 0, 0);
        @(negedge clock) begin
            bus.left_req = 1'b0;
            bus.right_req = 1'b0;
        end
        wait_edges(4); check("hazard_last_on", 3, 1, 7, 7);
        wait_edges(4); check("hazard_to_idle", 0, 0, 0, 0);
        @(negedge clock) bus.right_req = 1'b1;
        wait_edges(4); check("right_start", 2, 0, 0, 0);
        wait_edges(4); check("right_001", 2, 1, 0, 1);
        wait_edges(4); check("right_011", 2, 2, 0, 3);
        #1 reset_n = 1'b0;
        #1 check("async_reset", 0, 0, 0, 0);
        #1 reset_n = 1'b1;
        wait_edges(3); check("restart_edge3", 0, 0, 0, 0);
        wait_edges(1); check("restart_edge4", 2, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 11) == 0) bus.left_req = ~bus.left_req;
            if ($urandom_range(0, 11) == 0) bus.right_req = ~bus.right_req;
            if ($urandom_range(0, 29) == 0) bus.hazard_req = ~bus.hazard_req;
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clock);
                #2 reset_n = 1'b0;
                #1 check("rand_reset", 0, 0, 0, 0);
                #1 reset_n = 1'b1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter LEDS, default 3: lamps per side; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 4: clock cycles per sequence step; legal range >= 1.
REQ-003 Parameter SW = $clog2(LEDS+1): width of the step output.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 left_req  input  1  left turn request, level, synchronous to clock.
REQ-007 right_req  input  1  right turn request, level.
REQ-008 hazard_req  input  1  hazard request, level.
REQ-009 left_leds  output  LEDS  left lamps; bit 0 is the innermost lamp.
REQ-010 right_leds  output  LEDS  right lamps; bit 0 is the innermost lamp.
REQ-011 mode  output  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
REQ-012 step  output  SW  current step index; drives the existing seven-segment decoder.

Function
REQ-013 Prescaler shall count 0..TICK_DIV-1 and wrap; tick shall be high in the cycle where prescaler == TICK_DIV-1.
REQ-014 With TICK_DIV=1, tick shall be high every cycle.
REQ-015 Mode and step shall update only on a rising edge where tick is high; between ticks they shall hold.
REQ-016 Effective request shall be, in priority order: HAZARD if hazard_req or (left_req and right_req); else LEFT if left_req; else RIGHT if right_req; else IDLE.
REQ-017 IDLE, on tick: mode <= effective request, step <= 0.
REQ-018 LEFT/RIGHT, on tick with effective request HAZARD: mode <= HAZARD, step <= 0 (preemption, no wait for sequence end).
REQ-019 LEFT/RIGHT, on tick with step < LEDS and no hazard: step <= step+1; mode unchanged, even if the request dropped or changed.
REQ-020 LEFT/RIGHT, on tick with step == LEDS: step <= 0 and mode <= effective request (re-evaluated only at the sequence boundary).
REQ-021 HAZARD, on tick with step == 0: step <= 1.
REQ-022 HAZARD, on tick with step == 1: step <= 0 and mode <= effective request.
REQ-023 LEFT: left_leds shall be a thermometer code with the lowest step bits set (step 0 -> all off, step LEDS -> all on); right_leds = 0.
REQ-024 RIGHT: mirror of REQ-023 on right_leds; left_leds = 0.
REQ-025 HAZARD: both sides all ones when step == 1, all zeros when step == 0.
REQ-026 IDLE: both sides 0.
REQ-027 LED outputs shall be a pure decode of registered mode and step, with zero added latency.

Reset
REQ-028 Asserting reset_n low shall immediately force prescaler = 0, mode = IDLE, step = 0, and all LEDs = 0, regardless of clock.
REQ-029 After reset_n deasserts, the first tick shall occur on the TICK_DIV-th rising edge.
REQ-030 Reset asserted mid-sequence shall discard the sequence; no partial state shall persist.

Verification (LEDS=3, TICK_DIV=4)
REQ-031 Reset sequence: reset_n low for 2 cycles -> mode=0, step=0, left_leds=right_leds=000; after release, first tick on edge 4.
REQ-032 left_req held -> mode=1; left_leds = 000, 001, 011, 111, 000, ..., each value held 4 cycles; right_leds stays 000.
REQ-033 left_req held, hazard_req pulsed high across the tick where step==2 -> next tick mode=3, both sides 000; then both 111 for 4 cycles.
REQ-034 left_req dropped while step==1 -> sequence continues through 011, 111; at the next tick mode=0 and LEDs 000.
REQ-035 left_req and right_req asserted together from IDLE -> mode=3; both sides alternate 000/111 every 4 cycles.
REQ-036 reset_n pulsed low mid-cycle while step==2 in RIGHT -> right_leds=000 and mode=0 before the next clock edge; prescaler restarts at 0.
